// File: rtl/game_sequencer.sv
// Game sequencer: debounces the three push buttons, turns each accepted
// rising edge into a one-cycle press event, and runs the
// START/MENU/READY/PLAY/FINISH flow that selects a song, counts down on
// beat ticks and hands control to the note shifter.
module game_sequencer #(
    parameter int DEB_CYCLES  = 4,
    parameter int COUNT_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       red_button,
    input  logic       blue_button,
    input  logic       yellow_button,
    input  logic       finish,
    output logic [1:0] state,
    output logic [1:0] song_select,
    output logic [1:0] song_confirm,
    output logic       song_start,
    output logic       play_en,
    output logic       score_clr,
    output logic [1:0] countdown
);

    localparam int              CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [1:0]      CD_LOAD  = 2'(COUNT_TICKS);

    // Button lanes: bit 0 red, bit 1 blue, bit 2 yellow.
    localparam int B_RED    = 0;
    localparam int B_BLUE   = 1;
    localparam int B_YELLOW = 2;

    typedef enum logic [2:0] {
        S_START,
        S_MENU,
        S_READY,
        S_PLAY,
        S_FINISH
    } fsm_t;

    // Display encodings on the state port; READY and PLAY share one code.
    localparam logic [1:0] D_START  = 2'd0;
    localparam logic [1:0] D_MENU   = 2'd1;
    localparam logic [1:0] D_PLAY   = 2'd2;
    localparam logic [1:0] D_FINISH = 2'd3;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [CW-1:0] deb_cnt [3];
    logic [2:0]    press;
    fsm_t          fsm;

    assign raw   = {yellow_button, blue_button, red_button};
    assign press = deb & ~deb_q;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: count consecutive samples that disagree with the accepted
    // level; flip the level on the DEB_CYCLES-th one, restart on agreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == CNT_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Delayed copy of the debounced levels for rising-edge press detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb;
        end
    end

    // Game flow FSM with all outputs registered. score_clr is high only in
    // the first READY cycle, so it doubles as the "ignore this tick" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm          <= S_START;
            state        <= D_START;
            song_select  <= 2'd1;
            song_confirm <= 2'd0;
            song_start   <= 1'b0;
            play_en      <= 1'b0;
            score_clr    <= 1'b0;
            countdown    <= 2'd0;
        end else begin
            song_start <= 1'b0;
            score_clr  <= 1'b0;
            case (fsm)
                S_START: begin
                    if (press[B_RED] || press[B_BLUE]) begin
                        fsm   <= S_MENU;
                        state <= D_MENU;
                    end
                end
                S_MENU: begin
                    if (press[B_YELLOW]) begin
                        fsm          <= S_READY;
                        state        <= D_PLAY;
                        song_confirm <= song_select;
                        countdown    <= CD_LOAD;
                        score_clr    <= 1'b1;
                    end else if (press[B_RED]) begin
                        song_select <= (song_select == 2'd1) ? 2'd3 : song_select - 2'd1;
                    end else if (press[B_BLUE]) begin
                        song_select <= (song_select == 2'd3) ? 2'd1 : song_select + 2'd1;
                    end
                end
                S_READY: begin
                    if (press[B_YELLOW]) begin
                        fsm          <= S_MENU;
                        state        <= D_MENU;
                        song_confirm <= 2'd0;
                        countdown    <= 2'd0;
                    end else if (tick && !score_clr) begin
                        if (countdown == 2'd1) begin
                            fsm        <= S_PLAY;
                            countdown  <= 2'd0;
                            song_start <= 1'b1;
                            play_en    <= 1'b1;
                        end else begin
                            countdown <= countdown - 2'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (finish) begin
                        fsm          <= S_FINISH;
                        state        <= D_FINISH;
                        play_en      <= 1'b0;
                        song_confirm <= 2'd0;
                    end
                end
                S_FINISH: begin
                    if (press[B_YELLOW]) begin
                        fsm   <= S_MENU;
                        state <= D_MENU;
                    end
                end
                default: begin
                    fsm          <= S_START;
                    state        <= D_START;
                    song_confirm <= 2'd0;
                    play_en      <= 1'b0;
                    countdown    <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, hand-written reset
// sequences, and random button/tick/finish traffic against a reference
// model built from the game rules.
module tb_game_sequencer;

    localparam int DEB = 4;
    localparam int CNT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       red = 1'b0;
    logic       blue = 1'b0;
    logic       yellow = 1'b0;
    logic       finish = 1'b0;
    logic [1:0] state;
    logic [1:0] song_select;
    logic [1:0] song_confirm;
    logic       song_start;
    logic       play_en;
    logic       score_clr;
    logic [1:0] countdown;

    game_sequencer #(.DEB_CYCLES(DEB), .COUNT_TICKS(CNT)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .red_button(red),
        .blue_button(blue),
        .yellow_button(yellow),
        .finish(finish),
        .state(state),
        .song_select(song_select),
        .song_confirm(song_confirm),
        .song_start(song_start),
        .play_en(play_en),
        .score_clr(score_clr),
        .countdown(countdown)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    int ss_cnt = 0;
    int sc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 START, 1 MENU, 2 READY, 3 PLAY, 4 FINISH.
    // A button's accepted level follows the synchronized input once the last
    // DEB samples agree; a press is a 0->1 change of that accepted level,
    // acted on one edge after it appears.
    int         m_phase;
    int         m_age;
    int         m_sel;
    int         m_lock;
    int         m_cd;
    logic [2:0] m_deb;
    logic [2:0] m_deb_prev;
    logic [2:0] hist[$];

    function automatic void model_reset();
        m_phase    = 0;
        m_age      = 0;
        m_sel      = 1;
        m_lock     = 0;
        m_cd       = 0;
        m_deb      = '0;
        m_deb_prev = '0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(3'b000);
    endfunction

    function automatic void model_step(input logic [2:0] raw, input logic t, input logic f);
        logic [2:0] ev;
        int         nxt;
        ev = m_deb & ~m_deb_prev;
        hist.push_back(raw);
        if (hist.size() > DEB + 4) void'(hist.pop_front());
        m_deb_prev = m_deb;
        for (int b = 0; b < 3; b++) begin
            int ones;
            ones = 0;
            for (int j = 2; j <= DEB + 1; j++) ones += int'(hist[hist.size() - 1 - j][b]);
            if (ones == DEB) m_deb[b] = 1'b1;
            else if (ones == 0) m_deb[b] = 1'b0;
        end
        nxt = m_phase;
        case (m_phase)
            0: if (ev[0] || ev[1]) nxt = 1;
            1: begin
                if (ev[2]) begin
                    nxt = 2;
                    m_lock = m_sel;
                    m_cd = CNT;
                end else if (ev[0]) m_sel = (m_sel == 1) ? 3 : m_sel - 1;
                else if (ev[1]) m_sel = (m_sel == 3) ? 1 : m_sel + 1;
            end
            2: begin
                if (ev[2]) nxt = 1;
                else if (t && m_age > 0) begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) nxt = 3;
                end
            end
            3: if (f) nxt = 4;
            default: if (ev[2]) nxt = 1;
        endcase
        if (nxt != m_phase) m_age = 0;
        else if (m_age < 1000) m_age++;
        m_phase = nxt;
    endfunction

    function automatic logic [10:0] model_outputs();
        int st, conf, cd;
        st   = (m_phase == 0) ? 0 : (m_phase == 1) ? 1 : (m_phase == 4) ? 3 : 2;
        conf = (m_phase == 2 || m_phase == 3) ? m_lock : 0;
        cd   = (m_phase == 2) ? m_cd : 0;
        return {2'(st), 2'(m_sel), 2'(conf),
                (m_phase == 3 && m_age == 0), (m_phase == 3),
                (m_phase == 2 && m_age == 0), 2'(cd)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step({yellow, blue, red}, tick, finish);
        #1;
        check("cycle_outputs",
              32'({state, song_select, song_confirm, song_start, play_en, score_clr, countdown}),
              32'(model_outputs()));
        if (song_start) ss_cnt++;
        if (score_clr) sc_cnt++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_song_select"}, 32'(song_select), 1);
        check({tag, "_song_confirm"}, 32'(song_confirm), 0);
        check({tag, "_song_start"}, 32'(song_start), 0);
        check({tag, "_play_en"}, 32'(play_en), 0);
        check({tag, "_score_clr"}, 32'(score_clr), 0);
        check({tag, "_countdown"}, 32'(countdown), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        int         kind;     // 0 button press, 1 tick pulse, 2 finish pulse
        logic [2:0] btn;      // {yellow, blue, red}
        int         hold;
        int         e_state;
        int         e_sel;
        int         e_conf;
        int         e_cd;
        int         e_play;
        int         e_sc;     // cumulative score_clr cycles
        int         e_ss;     // cumulative song_start cycles
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string name, input int kind, input logic [2:0] btn,
                                input int hold, input int st, input int sel, input int conf,
                                input int cd, input int play, input int sc, input int ss);
        vec_t v;
        v.name = name; v.kind = kind; v.btn = btn; v.hold = hold;
        v.e_state = st; v.e_sel = sel; v.e_conf = conf; v.e_cd = cd;
        v.e_play = play; v.e_sc = sc; v.e_ss = ss;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        case (v.kind)
            0: begin
                {yellow, blue, red} = v.btn;
                repeat (v.hold) cycle();
                {yellow, blue, red} = 3'b000;
                repeat (14) cycle();
            end
            1: begin
                tick = 1'b1;
                cycle();
                tick = 1'b0;
                repeat (2) cycle();
            end
            default: begin
                finish = 1'b1;
                cycle();
                finish = 1'b0;
                repeat (2) cycle();
            end
        endcase
        check({v.name, "_state"}, 32'(state), v.e_state);
        check({v.name, "_song_select"}, 32'(song_select), v.e_sel);
        check({v.name, "_song_confirm"}, 32'(song_confirm), v.e_conf);
        check({v.name, "_countdown"}, 32'(countdown), v.e_cd);
        check({v.name, "_play_en"}, 32'(play_en), v.e_play);
        check({v.name, "_score_clr_cycles"}, sc_cnt, v.e_sc);
        check({v.name, "_song_start_cycles"}, ss_cnt, v.e_ss);
    endtask

    task automatic rand_cycle();
        tick   = ($urandom_range(0, 2) == 0);
        finish = ($urandom_range(0, 11) == 0);
        cycle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int found;

        model_reset();
        repeat (3) cycle();
        check_reset_values("reset");
        rst = 1'b0;
        repeat (3) cycle();

        // Red held 20 cycles: MENU exactly DEB+3 edges after the raw rise, one event only.
        red = 1'b1;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (found == 0 && state == 2'd1) found = i;
        end
        red = 1'b0;
        repeat (14) cycle();
        check("red_to_menu_edges", found, DEB + 3);
        check("red_held_song_select", 32'(song_select), 1);

        vt.push_back(mk("menu_red_wrap",      0, 3'b001, 8, 1, 3, 0, 0, 0, 0, 0));
        vt.push_back(mk("menu_blue_wrap",     0, 3'b010, 8, 1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk("menu_blue_inc",      0, 3'b010, 8, 1, 2, 0, 0, 0, 0, 0));
        vt.push_back(mk("menu_red_bounce",    0, 3'b001, 3, 1, 2, 0, 0, 0, 0, 0));
        vt.push_back(mk("menu_finish_ignored",2, 3'b000, 0, 1, 2, 0, 0, 0, 0, 0));
        vt.push_back(mk("menu_yellow_ready",  0, 3'b100, 8, 2, 2, 2, 3, 0, 1, 0));
        vt.push_back(mk("ready_tick_1",       1, 3'b000, 0, 2, 2, 2, 2, 0, 1, 0));
        vt.push_back(mk("ready_red_ignored",  0, 3'b001, 8, 2, 2, 2, 2, 0, 1, 0));
        vt.push_back(mk("ready_yellow_abort", 0, 3'b100, 8, 1, 2, 0, 0, 0, 1, 0));
        vt.push_back(mk("menu_yellow_again",  0, 3'b100, 8, 2, 2, 2, 3, 0, 2, 0));
        vt.push_back(mk("ready_tick_a",       1, 3'b000, 0, 2, 2, 2, 2, 0, 2, 0));
        vt.push_back(mk("ready_tick_b",       1, 3'b000, 0, 2, 2, 2, 1, 0, 2, 0));
        vt.push_back(mk("ready_tick_play",    1, 3'b000, 0, 2, 2, 2, 0, 1, 2, 1));
        vt.push_back(mk("play_red_ignored",   0, 3'b001, 8, 2, 2, 2, 0, 1, 2, 1));
        vt.push_back(mk("play_blue_ignored",  0, 3'b010, 8, 2, 2, 2, 0, 1, 2, 1));
        vt.push_back(mk("play_yellow_ignored",0, 3'b100, 8, 2, 2, 2, 0, 1, 2, 1));
        vt.push_back(mk("play_finish",        2, 3'b000, 0, 3, 2, 0, 0, 0, 2, 1));
        vt.push_back(mk("finish_red_ignored", 0, 3'b001, 8, 3, 2, 0, 0, 0, 2, 1));
        vt.push_back(mk("finish_yellow_menu", 0, 3'b100, 8, 1, 2, 0, 0, 0, 2, 1));
        vt.push_back(mk("menu_all_yellow_wins",0,3'b111, 8, 2, 2, 2, 3, 0, 3, 1));
        vt.push_back(mk("ready_tick_to_2",    1, 3'b000, 0, 2, 2, 2, 2, 0, 3, 1));

        for (int i = 0; i < vt.size(); i++) apply_vec(vt[i]);

        // Asynchronous reset while countdown is 2: outputs clear before the next edge.
        rst = 1'b1;
        #1;
        check_reset_values("async_rst_ready");
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        repeat (10) cycle();
        check("rst_no_score_clr", sc_cnt, 3);
        check("rst_no_song_start", ss_cnt, 1);

        // Red held through reset release: MENU on edge DEB+3 after release.
        red = 1'b1;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (found == 0 && state == 2'd1) found = i;
        end
        red = 1'b0;
        repeat (14) cycle();
        check("held_through_rst_edges", found, DEB + 3);

        // Random traffic, checked every cycle against the model.
        for (int n = 0; n < 400; n++) begin
            {yellow, blue, red} = {($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1))};
            repeat ($urandom_range(1, 10)) rand_cycle();
            {yellow, blue, red} = 3'b000;
            repeat ($urandom_range(1, 10)) rand_cycle();
        end
        tick = 1'b0;
        finish = 1'b0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
